// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg : shared types and constants for the load/store sequencer  (rev 1.0)
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    // Width legality wins over alignment when both are wrong.
    function automatic logic [1:0] check_op(input logic store, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic width_ok;
        logic align_ok;
        width_ok = 1'b0;
        align_ok = 1'b1;
        case (f3)
            F3_B:  width_ok = 1'b1;
            F3_H:  begin width_ok = 1'b1;   align_ok = ~off[0];        end
            F3_W:  begin width_ok = 1'b1;   align_ok = (off == 2'b00); end
            F3_BU: width_ok = ~store;
            F3_HU: begin width_ok = ~store; align_ok = ~off[0];        end
            default: width_ok = 1'b0;
        endcase
        if (!width_ok)
            check_op = EXC_ILLEGAL;
        else if (!align_ok)
            check_op = EXC_MISALIGN;
        else
            check_op = EXC_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_store_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_store_align : byte strobes and lane-replicated store data  (rev 1.0)
// ----------------------------------------------------------------------------
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_al
);

    always_comb begin
        wstrb    = 4'b0000;
        wdata_al = 32'h0;
        case (func3)
            F3_B: begin
                wstrb    = 4'b0001 << off;
                wdata_al = {4{wdata[7:0]}};
            end
            F3_H: begin
                wstrb    = off[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            F3_W: begin
                wstrb    = 4'b1111;
                wdata_al = wdata;
            end
            default: begin
                wstrb    = 4'b0000;
                wdata_al = 32'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_ctrl : MEM-stage load/store sequencer with timeout and flush  (rev 1.0)
// ----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [2:0]  ld_func3,
    output logic [1:0]  ld_off,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    lsu_state_t        state, state_nx;
    logic              lat_store;
    logic [2:0]        lat_func3;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic              flushed;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]  chk;
    logic        accept, reject, in_txn, complete, abort, expire, kill;
    logic [3:0]  al_strb;
    logic [31:0] al_data;

    lsu_store_align u_align (
        .func3    (lat_func3),
        .off      (lat_addr[1:0]),
        .wdata    (lat_wdata),
        .wstrb    (al_strb),
        .wdata_al (al_data)
    );

    assign chk      = check_op(op_store, func3, addr[1:0]);
    assign accept   = (state == IDLE) && op_valid && !flush && (chk == EXC_NONE);
    assign reject   = (state == IDLE) && op_valid && !flush && (chk != EXC_NONE);
    assign in_txn   = (state == REQ) || (state == WAIT);
    assign complete = ((state == REQ) && dm_gnt && dm_rvalid) || ((state == WAIT) && dm_rvalid);
    assign abort    = (state == REQ) && flush && !dm_gnt;
    assign expire   = in_txn && !complete && !abort && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    // A flush in the completing cycle counts as well as one recorded earlier.
    assign kill     = flushed || flush;

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        dm_req   = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_nx = REQ;
            end
            REQ: begin
                stall  = 1'b1;
                dm_req = 1'b1;
                if (abort)                  state_nx = IDLE;
                else if (complete || expire) state_nx = DONE;
                else if (dm_gnt)            state_nx = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (complete || expire) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign dm_we    = dm_req && lat_store;
    assign dm_wstrb = (dm_req && lat_store) ? al_strb : 4'b0000;
    assign dm_addr  = dm_req ? {lat_addr[31:2], 2'b00} : 32'h0;
    assign dm_wdata = (dm_req && lat_store) ? al_data : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_store <= 1'b0;
            lat_func3 <= 3'b000;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            flushed   <= 1'b0;
            cnt       <= '0;
            ld_valid  <= 1'b0;
            ld_data   <= 32'h0;
            ld_func3  <= 3'b000;
            ld_off    <= 2'b00;
            exc_valid <= 1'b0;
            exc_cause <= 2'b00;
            exc_addr  <= 32'h0;
        end else begin
            state     <= state_nx;
            ld_valid  <= 1'b0;
            exc_valid <= 1'b0;

            if (accept) begin
                lat_store <= op_store;
                lat_func3 <= func3;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                flushed   <= 1'b0;
                cnt       <= '0;
            end else if (in_txn) begin
                cnt <= cnt + 1'b1;
                if (flush) flushed <= 1'b1;
            end

            if (complete && !lat_store && !kill) begin
                ld_valid <= 1'b1;
                ld_data  <= dm_rdata;
                ld_func3 <= lat_func3;
                ld_off   <= lat_addr[1:0];
            end

            if (reject) begin
                exc_valid <= 1'b1;
                exc_cause <= chk;
                exc_addr  <= addr;
            end else if (expire && !kill) begin
                exc_valid <= 1'b1;
                exc_cause <= EXC_TIMEOUT;
                exc_addr  <= lat_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_ctrl : scoreboard bench for the load/store sequencer  (rev 1.0)
// ----------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0, op_store = 1'b0, flush = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        stall, dm_req, dm_we;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;
    logic [31:0] dm_rdata = 32'h0;
    logic        ld_valid, exc_valid;
    logic [31:0] ld_data, exc_addr;
    logic [2:0]  ld_func3;
    logic [1:0]  ld_off, exc_cause;

    lsu_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_store(op_store),
        .func3(func3), .addr(addr), .wdata(wdata), .flush(flush), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_func3(ld_func3), .ld_off(ld_off),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [3:0] strb; logic [31:0] a; logic [31:0] d; } req_t;
    typedef struct packed { logic [31:0] d; logic [2:0] f3; logic [1:0] off; } ld_t;
    typedef struct packed { logic [1:0] cause; logic [31:0] a; } exc_t;

    req_t exp_req[$];
    ld_t  exp_ld[$];
    exc_t exp_exc[$];
    req_t mon_r;
    ld_t  mon_l;
    exc_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   ld_seen = 0;
    int   exc_seen = 0;

    // Scoreboard side: every granted request, load pulse and exception pulse is popped here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_req && dm_gnt) begin
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected got addr=%h we=%b", dm_addr, dm_we);
                end else begin
                    mon_r = exp_req.pop_front();
                    if ({dm_we, dm_wstrb, dm_addr, dm_wdata} !== mon_r) begin
                        errors++;
                        $display("FAIL req_fields got we=%b strb=%b addr=%h data=%h want we=%b strb=%b addr=%h data=%h",
                                 dm_we, dm_wstrb, dm_addr, dm_wdata, mon_r.we, mon_r.strb, mon_r.a, mon_r.d);
                    end
                end
            end
            if (ld_valid) begin
                ld_seen++;
                checks++;
                if (exp_ld.size() == 0) begin
                    errors++;
                    $display("FAIL ld_unexpected got data=%h", ld_data);
                end else begin
                    mon_l = exp_ld.pop_front();
                    if ({ld_data, ld_func3, ld_off} !== mon_l) begin
                        errors++;
                        $display("FAIL ld_fields got data=%h f3=%b off=%0d want data=%h f3=%b off=%0d",
                                 ld_data, ld_func3, ld_off, mon_l.d, mon_l.f3, mon_l.off);
                    end
                end
            end
            if (exc_valid) begin
                exc_seen++;
                checks++;
                if (exp_exc.size() == 0) begin
                    errors++;
                    $display("FAIL exc_unexpected got cause=%b addr=%h", exc_cause, exc_addr);
                end else begin
                    mon_e = exp_exc.pop_front();
                    if ({exc_cause, exc_addr} !== mon_e) begin
                        errors++;
                        $display("FAIL exc_fields got cause=%b addr=%h want cause=%b addr=%h",
                                 exc_cause, exc_addr, mon_e.cause, mon_e.a);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and plays the memory side: gnt/rvalid/flush fire at cycle k after issue.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int gnt_at, input int rsp_at, input int flush_at,
                         output logic issue_stall, output int stall_n, output int req_n,
                         output logic done_ok);
        step();
        op_valid = 1'b1; op_store = st; func3 = f3; addr = a; wdata = wd; dm_rdata = rd;
        @(negedge clk);
        issue_stall = stall;
        stall_n = 0;
        req_n = dm_req ? 1 : 0;
        done_ok = 1'b0;
        if (!stall) begin
            step();
            op_valid = 1'b0;
            done_ok = 1'b1;
            return;
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            dm_gnt = (k == gnt_at);
            dm_rvalid = (k == rsp_at);
            flush = (k == flush_at);
            if (k == flush_at) op_valid = 1'b0;
            @(negedge clk);
            if (dm_req) req_n++;
            if (stall) stall_n++;
            else begin
                done_ok = 1'b1;
                break;
            end
        end
        step();
        op_valid = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({stall, dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata, ld_valid, ld_data, ld_func3,
             ld_off, exc_valid, exc_cause, exc_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b req=%b ld_valid=%b exc_valid=%b want all zero",
                     stall, dm_req, ld_valid, exc_valid);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        logic is; int sn, rn; logic ok; int l0;
        l0 = ld_seen;
        exp_req.push_back('{we: 1'b0, strb: 4'b0000, a: 32'h1000, d: 32'h0});
        exp_ld.push_back('{d: 32'hDEADBEEF, f3: 3'b010, off: 2'd0});
        do_op(1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 1, 2, 1000, is, sn, rn, ok);
        checks++;
        if (!(ok && is && sn == 2 && rn == 1)) begin
            errors++;
            $display("FAIL lw_timing got done=%b issue_stall=%b stall_n=%0d req_n=%0d want 1 1 2 1", ok, is, sn, rn);
        end
        checks++;
        if (ld_seen - l0 !== 1) begin
            errors++;
            $display("FAIL lw_ld_count got %0d want 1", ld_seen - l0);
        end
    endtask

    task automatic test_store_byte();
        logic is; int sn, rn; logic ok; int l0;
        l0 = ld_seen;
        exp_req.push_back('{we: 1'b1, strb: 4'b1000, a: 32'h2000, d: 32'hA5A5A5A5});
        do_op(1'b1, 3'b000, 32'h2003, 32'h000000A5, 32'h0, 1, 2, 1000, is, sn, rn, ok);
        checks++;
        if (!(ok && is && sn == 2) || ld_seen != l0) begin
            errors++;
            $display("FAIL sb_done got done=%b stall_n=%0d ld_pulses=%0d want 1 2 0", ok, sn, ld_seen - l0);
        end
        checks++;
        if (ld_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ld_data_hold got %h want deadbeef", ld_data);
        end
    endtask

    task automatic test_exceptions();
        logic [2:0]  f3s [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] as  [3] = '{32'h3001, 32'h3003, 32'h3006};
        logic        sts [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  cs  [3] = '{2'b01, 2'b11, 2'b01};
        logic is; int sn, rn; logic ok;
        for (int i = 0; i < 3; i++) begin
            exp_exc.push_back('{cause: cs[i], a: as[i]});
            do_op(sts[i], f3s[i], as[i], 32'h0, 32'h0, 1000, 1000, 1000, is, sn, rn, ok);
            checks++;
            if (is !== 1'b0 || rn != 0) begin
                errors++;
                $display("FAIL illegal_no_bus[%0d] got issue_stall=%b req_n=%0d want 0 0", i, is, rn);
            end
            @(negedge clk);
            checks++;
            if (exc_valid !== 1'b1 || stall !== 1'b0 || dm_req !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse[%0d] got exc=%b stall=%b req=%b want 1 0 0", i, exc_valid, stall, dm_req);
            end
            step();
            @(negedge clk);
            checks++;
            if (exc_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_one_cycle[%0d] got %b want 0", i, exc_valid);
            end
        end
    endtask

    task automatic test_timeout();
        logic is; int sn, rn; logic ok; int l0;
        l0 = ld_seen;
        exp_exc.push_back('{cause: 2'b10, a: 32'h6000});
        do_op(1'b0, 3'b000, 32'h6000, 32'h0, 32'h55555555, 1000, 1000, 1000, is, sn, rn, ok);
        checks++;
        if (!(ok && sn == TO && rn == TO)) begin
            errors++;
            $display("FAIL timeout_len got done=%b stall_n=%0d req_n=%0d want 1 %0d %0d", ok, sn, rn, TO, TO);
        end
        dm_rvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || ld_valid !== 1'b0 || exc_valid !== 1'b0 || ld_seen != l0) begin
            errors++;
            $display("FAIL late_rvalid got stall=%b ld=%b exc=%b want 0 0 0", stall, ld_valid, exc_valid);
        end
        step();
        dm_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (ld_valid !== 1'b0 || exc_addr !== 32'h6000) begin
            errors++;
            $display("FAIL late_rvalid_after got ld=%b exc_addr=%h want 0 6000", ld_valid, exc_addr);
        end
    endtask

    task automatic test_flush_wait();
        logic is; int sn, rn; logic ok; int l0, e0;
        l0 = ld_seen; e0 = exc_seen;
        exp_req.push_back('{we: 1'b0, strb: 4'b0000, a: 32'h7004, d: 32'h0});
        do_op(1'b0, 3'b010, 32'h7004, 32'h0, 32'h11223344, 1, 3, 2, is, sn, rn, ok);
        checks++;
        if (!(ok && sn == 3) || ld_seen != l0 || exc_seen != e0) begin
            errors++;
            $display("FAIL flush_wait got done=%b stall_n=%0d ld=%0d exc=%0d want 1 3 0 0",
                     ok, sn, ld_seen - l0, exc_seen - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic is; int sn, rn; logic ok;
        exp_req.push_back('{we: 1'b1, strb: 4'b1100, a: 32'h2000, d: 32'hBEEFBEEF});
        do_op(1'b1, 3'b001, 32'h2002, 32'h1234BEEF, 32'h0, 1, 1, 1000, is, sn, rn, ok);
        checks++;
        if (!(ok && is && sn == 1)) begin
            errors++;
            $display("FAIL same_cycle got done=%b issue_stall=%b stall_n=%0d want 1 1 1", ok, is, sn);
        end
        exp_req.push_back('{we: 1'b0, strb: 4'b0000, a: 32'h8000, d: 32'h0});
        exp_ld.push_back('{d: 32'hA1B2C3D4, f3: 3'b101, off: 2'd2});
        do_op(1'b0, 3'b101, 32'h8002, 32'h0, 32'hA1B2C3D4, 2, 3, 1000, is, sn, rn, ok);
        checks++;
        if (!(ok && sn == 3 && rn == 2)) begin
            errors++;
            $display("FAIL lhu_late_gnt got done=%b stall_n=%0d req_n=%0d want 1 3 2", ok, sn, rn);
        end
        checks++;
        if (exc_addr !== 32'h6000) begin
            errors++;
            $display("FAIL exc_addr_hold got %h want 00006000", exc_addr);
        end
    endtask

    task automatic test_reset_mid();
        logic is; int sn, rn; logic ok;
        exp_req.push_back('{we: 1'b0, strb: 4'b0000, a: 32'h5000, d: 32'h0});
        step();
        op_valid = 1'b1; op_store = 1'b0; func3 = 3'b010; addr = 32'h5000;
        step();
        dm_gnt = 1'b1;
        step();
        dm_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_wait got stall=%b req=%b want 1 0", stall, dm_req);
        end
        rst_n = 1'b0;
        op_valid = 1'b0;
        #1;
        checks++;
        if (dm_req !== 1'b0 || stall !== 1'b0 || exc_valid !== 1'b0 || ld_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got req=%b stall=%b exc=%b ld=%b want 0 0 0 0", dm_req, stall, exc_valid, ld_valid);
        end
        step();
        step();
        rst_n = 1'b1;
        exp_req.push_back('{we: 1'b1, strb: 4'b1111, a: 32'h4000, d: 32'hCAFEF00D});
        do_op(1'b1, 3'b010, 32'h4000, 32'hCAFEF00D, 32'h0, 1, 2, 1000, is, sn, rn, ok);
        checks++;
        if (!(ok && is && sn == 2 && rn == 1)) begin
            errors++;
            $display("FAIL sw_after_reset got done=%b stall_n=%0d req_n=%0d want 1 2 1", ok, sn, rn);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_exceptions();
        test_timeout();
        test_flush_wait();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_req.size() != 0 || exp_ld.size() != 0 || exp_exc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got req=%0d ld=%0d exc=%0d want 0 0 0",
                     exp_req.size(), exp_ld.size(), exp_exc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
